// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the FIFO write-port arbiter.
// The top module derives its own widths from its parameters.
package fifo_arb_pkg;
    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_e;

    localparam int NUM_REQ_DEF   = 4;
    localparam int MAX_BURST_DEF = 4;
    localparam int OWNER_W       = $clog2(NUM_REQ_DEF);
    localparam int CNT_W         = $clog2(MAX_BURST_DEF + 1);
endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin search: first set request at or above ptr, wrapping.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int OWN_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [OWN_W-1:0]   ptr,
    output logic               any_valid,
    output logic [OWN_W-1:0]   winner
);
    logic [NUM_REQ-1:0] rot;
    logic [OWN_W:0]     off;
    logic [OWN_W:0]     idx;

    always_comb begin
        // Doubling the vector turns the wrap-around search into a plain shift.
        rot       = NUM_REQ'({req, req} >> ptr);
        any_valid = |req;
        off       = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) off = (OWN_W + 1)'(i);
        end
        idx = {1'b0, ptr} + off;
        if (idx >= (OWN_W + 1)'(NUM_REQ)) idx = idx - (OWN_W + 1)'(NUM_REQ);
        winner = idx[OWN_W-1:0];
    end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NUM_REQ requesters.
// Writes are gated on fifo_full here because the FIFO memory does not gate them.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int NUM_REQ    = NUM_REQ_DEF,
    parameter  int DATA_WIDTH = 8,
    parameter  int MAX_BURST  = MAX_BURST_DEF,
    localparam int OWN_W      = $clog2(NUM_REQ),
    localparam int BC_W       = $clog2(MAX_BURST + 1)
) (
    input  logic                          wclk,
    input  logic                          wrst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_w_en,
    output logic [DATA_WIDTH-1:0]         fifo_data_in,
    output logic [OWN_W-1:0]              owner,
    output logic                          busy,
    output logic [BC_W-1:0]               beat_cnt
);
    state_e           state_q;
    logic [OWN_W-1:0] owner_q;
    logic [OWN_W-1:0] rr_ptr_q;
    logic [OWN_W-1:0] rr_ptr_d;
    logic [BC_W-1:0]  beat_cnt_q;
    logic [OWN_W-1:0] winner;
    logic             any_valid;
    logic             granted;
    logic             xfer;
    logic             burst_end;

    rr_pick #(.NUM_REQ(NUM_REQ), .OWN_W(OWN_W)) u_pick (
        .req       (req_valid),
        .ptr       (rr_ptr_q),
        .any_valid (any_valid),
        .winner    (winner)
    );

    always_comb begin
        granted      = (state_q == GRANT);
        xfer         = granted & req_valid[owner_q] & ~fifo_full;
        burst_end    = req_last[owner_q] | (beat_cnt_q == BC_W'(MAX_BURST - 1));
        rr_ptr_d     = (owner_q == OWN_W'(NUM_REQ - 1)) ? '0 : owner_q + OWN_W'(1);
        req_ready    = (granted & ~fifo_full) ? (NUM_REQ'(1) << owner_q) : '0;
        fifo_w_en    = xfer;
        fifo_data_in = req_data[owner_q*DATA_WIDTH +: DATA_WIDTH];
    end

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_valid) begin
                        owner_q    <= winner;
                        beat_cnt_q <= '0;
                        state_q    <= GRANT;
                    end
                end
                GRANT: begin
                    // A stalled or absent beat holds both grant and count.
                    if (xfer) begin
                        if (burst_end) begin
                            rr_ptr_q   <= rr_ptr_d;
                            beat_cnt_q <= '0;
                            state_q    <= IDLE;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + BC_W'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy     = granted;
    assign owner    = owner_q;
    assign beat_cnt = beat_cnt_q;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus random traffic, all checked
// each cycle against a behavioural model of the arbitration rules.
module tb_fifo_wr_arbiter;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 4;

    logic          wclk = 1'b0;
    logic          wrst;
    logic [N-1:0]  req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]  req_last;
    logic [N-1:0]  req_ready;
    logic          fifo_full;
    logic          fifo_w_en;
    logic [DW-1:0] fifo_data_in;
    logic [1:0]    owner;
    logic          busy;
    logic [2:0]    beat_cnt;

    fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .wclk         (wclk),
        .wrst         (wrst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .fifo_full    (fifo_full),
        .fifo_w_en    (fifo_w_en),
        .fifo_data_in (fifo_data_in),
        .owner        (owner),
        .busy         (busy),
        .beat_cnt     (beat_cnt)
    );

    always #5 wclk = ~wclk;

    int errors = 0;
    int checks = 0;

    // Model: whether a burst is in progress, who holds it, beats accepted so far,
    // and where the next search starts.
    bit m_busy;
    int m_owner;
    int m_beats;
    int m_ptr;

    int wr_owner[$];
    int wr_data[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        m_owner = 0;
        m_beats = 0;
        m_ptr   = 0;
    endtask

    // One clock: called at a falling edge with inputs already applied.
    task automatic step();
        logic [N-1:0] er;
        bit ew;
        #1;
        ew = m_busy && !fifo_full && req_valid[m_owner];
        er = (m_busy && !fifo_full) ? N'(1 << m_owner) : '0;
        chk("req_ready", 32'(req_ready), 32'(er));
        chk("fifo_w_en", 32'(fifo_w_en), 32'(ew));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("owner", 32'(owner), 32'(m_owner));
        chk("beat_cnt", 32'(beat_cnt), 32'(m_beats));
        if (ew) begin
            chk("fifo_data_in", 32'(fifo_data_in), 32'(req_data[m_owner*DW +: DW]));
            wr_owner.push_back(m_owner);
            wr_data.push_back(int'(fifo_data_in));
        end
        @(posedge wclk);
        if (!m_busy) begin
            for (int k = 0; k < N; k++) begin
                if (!m_busy && req_valid[(m_ptr + k) % N]) begin
                    m_busy  = 1'b1;
                    m_owner = (m_ptr + k) % N;
                    m_beats = 0;
                end
            end
        end else if (ew) begin
            m_beats++;
            if (req_last[m_owner] || m_beats == MB) begin
                m_busy  = 1'b0;
                m_ptr   = (m_owner + 1) % N;
                m_beats = 0;
            end
        end
        @(negedge wclk);
    endtask

    task automatic pulse_reset();
        wrst = 1'b1;
        #1;
        model_reset();
        @(negedge wclk);
        wrst = 1'b0;
        wr_owner.delete();
        wr_data.delete();
    endtask

    initial begin
        int sent;
        wrst      = 1'b1;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        fifo_full = 1'b0;
        model_reset();
        @(negedge wclk);
        @(negedge wclk);
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_beat", 32'(beat_cnt), 32'h0);
        wrst = 1'b0;

        // Reset asserted in the middle of a grant
        req_valid = 4'b1111;
        req_data  = 32'h33221100;
        step(); step(); step();
        chk("pre_rst_busy", 32'(busy), 32'h1);
        wrst = 1'b1;
        #1;
        chk("async_rst_ready", 32'(req_ready), 32'h0);
        chk("async_rst_wen", 32'(fifo_w_en), 32'h0);
        chk("async_rst_owner", 32'(owner), 32'h0);
        model_reset();
        @(negedge wclk);
        wrst = 1'b0;
        step();
        chk("first_grant_owner", 32'(owner), 32'h0);
        chk("first_grant_busy", 32'(busy), 32'h1);

        // Round-robin with single-beat bursts
        pulse_reset();
        req_valid = 4'b1111;
        req_last  = 4'b1111;
        for (int c = 0; c < 10; c++) step();
        chk("rr_writes", 32'(wr_owner.size()), 32'd5);
        for (int i = 0; i < 5 && i < wr_owner.size(); i++)
            chk("rr_owner_seq", 32'(wr_owner[i]), 32'(i % 4));

        // Burst cap on a streaming requester
        pulse_reset();
        req_valid = 4'b0100;
        req_last  = '0;
        sent = 0;
        for (int c = 0; c < 10; c++) begin
            req_data = '0;
            req_data[2*DW +: DW] = 8'(8'hA0 + sent);
            step();
            sent = wr_data.size();
        end
        chk("cap_writes", 32'(wr_data.size()), 32'd8);
        for (int i = 0; i < 8 && i < wr_data.size(); i++) begin
            chk("cap_data", 32'(wr_data[i]), 32'(8'hA0 + i));
            chk("cap_owner", 32'(wr_owner[i]), 32'd2);
        end

        // FIFO full stall mid-burst
        pulse_reset();
        req_valid = 4'b0010;
        req_data  = 32'h0000_5500;
        step(); step(); step();
        fifo_full = 1'b1;
        for (int c = 0; c < 3; c++) step();
        chk("stall_beat", 32'(beat_cnt), 32'd2);
        chk("stall_owner", 32'(owner), 32'd1);
        chk("stall_writes", 32'(wr_data.size()), 32'd2);
        fifo_full = 1'b0;
        step(); step();
        chk("stall_done_busy", 32'(busy), 32'h0);
        chk("stall_total", 32'(wr_data.size()), 32'd4);

        // Fairness between requesters 0 and 3
        pulse_reset();
        req_valid = 4'b1001;
        req_data  = 32'h4400_0011;
        for (int c = 0; c < 20; c++) step();
        chk("fair_writes", 32'(wr_owner.size()), 32'd16);
        for (int b = 0; b < 4 && 4*b < wr_owner.size(); b++)
            chk("fair_owner", 32'(wr_owner[4*b]), (b % 2 == 0) ? 32'd0 : 32'd3);

        // Owner drops valid mid-burst while another requester waits
        pulse_reset();
        req_valid = 4'b0010;
        step(); step();
        req_valid = 4'b0001;
        step();
        chk("gap_ready0", 32'(req_ready[0]), 32'h0);
        step();
        chk("gap_owner", 32'(owner), 32'd1);
        req_valid = 4'b0011;
        step(); step(); step();
        chk("gap_writes", 32'(wr_owner.size()), 32'd4);
        step(); step();
        chk("gap_next_owner", 32'(owner), 32'd0);

        // Random traffic
        pulse_reset();
        for (int c = 0; c < 400; c++) begin
            req_valid = N'($urandom);
            req_last  = N'($urandom & $urandom);
            req_data  = $urandom;
            fifo_full = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Write-side arbiter that shares one async FIFO write port between NUM_REQ requesters in the wclk domain.
- Grants one requester at a time, round-robin, and holds the grant for a burst. The burst ends on the requester's last beat or after MAX_BURST beats.
- Drives the FIFO w_en/data_in pair. Never asserts w_en while full is high; this is required because the FIFO memory itself does not gate writes on full.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_WIDTH, 8, FIFO data width
- MAX_BURST, 4, maximum beats per grant (1..16)

Ports:
- wclk  in  1  write-domain clock; all logic is on its rising edge
- wrst  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester data valid
- req_data  in  NUM_REQ*DATA_WIDTH  packed data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_last  in  NUM_REQ  marks the final beat of a requester's burst
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
- fifo_full  in  1  FIFO full flag (wclk domain)
- fifo_w_en  out  1  FIFO write enable
- fifo_data_in  out  DATA_WIDTH  FIFO write data
- owner  out  clog2(NUM_REQ)  index of the current grant holder
- busy  out  1  high while in GRANT state
- beat_cnt  out  clog2(MAX_BURST+1)  beats transferred in the current burst

Behaviour:
- Reset (wrst=1, asynchronous):
  - state=IDLE, rr_ptr=0, owner=0, beat_cnt=0, busy=0.
  - req_ready=0 and fifo_w_en=0 immediately (combinational from state).
- Reset mid-burst abandons the burst. No partial-burst tracking is kept.
- FSM states are IDLE and GRANT.
- IDLE:
  - req_ready=0.
  - If any req_valid is high, pick the winner: the first valid index searching upward from rr_ptr, wrapping at NUM_REQ.
  - Register the winner into owner, set beat_cnt=0, go to GRANT.
  - Arbitration latency is 1 cycle from valid to ready.
- GRANT:
  - req_ready[owner] = !fifo_full; all other req_ready bits are 0.
  - A transfer occurs when req_valid[owner] & req_ready[owner].
  - fifo_w_en = transfer; fifo_data_in = req_data slice of owner.
  - Both are combinational, so there is zero latency from handshake to FIFO write.
- fifo_data_in equals the owner's slice in every state. Its value is don't-care when fifo_w_en=0.
- On a transfer:
  - beat_cnt increments.
  - If req_last[owner] is high, or beat_cnt==MAX_BURST-1, the burst ends: rr_ptr <= owner+1 (mod NUM_REQ), beat_cnt <= 0, go to IDLE.
- Owner drops req_valid mid-burst: the grant is held, with no timeout. The requester is obliged to finish the burst.
- fifo_full high: req_ready drops in the same cycle and no write occurs. The grant and beat_cnt are held and resume when full falls.
- Back-to-back bursts:
  - Every burst end spends one IDLE cycle.
  - Peak throughput is MAX_BURST/(MAX_BURST+1) beats per cycle.
- Fairness: a requester that keeps req_valid high is granted within NUM_REQ-1 other bursts.
- Single requester: re-granted after each IDLE cycle, because rr_ptr wraps back to it.
- req_last on a beat that is not accepted has no effect. Only accepted beats count.
- busy = (state==GRANT).

Decomposition:
- Package fifo_arb_pkg:
  - state enum {IDLE, GRANT}
  - localparams OWNER_W=clog2(NUM_REQ) and CNT_W=clog2(MAX_BURST+1)
- One sub-module, rr_pick:
  - Combinational round-robin search.
  - Inputs: req vector, rr_ptr. Outputs: any_valid, winner index.
  - Implemented as a doubled-vector mask.
- The top module holds the FSM, counters and output muxing.

Test Plan (NUM_REQ=4, MAX_BURST=4, DATA_WIDTH=8):
1. Reset: assert wrst mid-GRANT with req_valid=4'b1111 -> req_ready=0 and fifo_w_en=0 in the same cycle. After release, the first grant goes to requester 0.
2. Round-robin: hold req_valid=4'b1111 with req_last high on every beat -> owner sequence 0,1,2,3,0. Exactly one fifo_w_en per grant, each followed by one idle cycle.
3. Burst cap: requester 2 streams 0xA0..0xA9 with req_last low -> beats A0..A3 are written, then an IDLE cycle, then a re-grant to 2 for A4..A7. beat_cnt reads 0..3 in each burst.
4. Full stall: fifo_full=1 for 3 cycles mid-burst after 2 beats -> req_ready=0 and fifo_w_en=0 for those 3 cycles, owner unchanged. The burst resumes with beat_cnt=2 and ends after 2 more beats.
5. Fairness: req_valid=4'b1001 continuously, bursts of 4 -> grants alternate 0,3,0,3. Requester 3 never waits more than one burst.
6. Valid gap: owner 1 drops req_valid for 2 cycles mid-burst -> the grant is held, and no other requester gets req_ready even though req_valid[0] is high.
